// File: rtl/ecc_operand_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ecc_operand_ctrl
// Brief   : Serialises host words into ECC engine operands, launches the
//           engine and streams its results back out. Optional engine watchdog
//           is compiled in with `define ECC_OPERAND_CTRL_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module ecc_operand_ctrl #(
  parameter int WORD_W      = 64,
  parameter int OPND_W      = 164,
  parameter int NUM_IN      = 3,
  parameter int NUM_OUT     = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WORD_W-1:0]         data_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [NUM_IN*OPND_W-1:0]  eng_in,
  output logic                      eng_start,
  input  logic                      eng_done,
  input  logic [NUM_OUT*OPND_W-1:0] eng_out,
  output logic [WORD_W-1:0]         data_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      error
);

  localparam int c_wpo   = (OPND_W + WORD_W - 1) / WORD_W;
  localparam int c_pad_w = c_wpo * WORD_W;
  localparam int c_top_w = OPND_W - (c_wpo - 1) * WORD_W;
  localparam int c_n_ld  = NUM_IN * c_wpo;
  localparam int c_n_ul  = NUM_OUT * c_wpo;
  localparam int c_n_max = (c_n_ld > c_n_ul) ? c_n_ld : c_n_ul;
  localparam int c_idx_w = (c_n_max > 1) ? $clog2(c_n_max) : 1;
  localparam logic [c_idx_w-1:0] c_last_ld = c_idx_w'(c_n_ld - 1);
  localparam logic [c_idx_w-1:0] c_last_ul = c_idx_w'(c_n_ul - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_UNLOAD = 3'd4
`ifdef ECC_OPERAND_CTRL_TIMEOUT_EN
    ,
    ST_ERR    = 3'd5
`endif
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [c_idx_w-1:0]        r_idx;
  logic [NUM_OUT*OPND_W-1:0] r_res;
  logic [c_n_ul*WORD_W-1:0]  w_res_pad;
  logic                      w_in_xfer;
  logic                      w_out_xfer;
  logic                      w_wd_expired;

  assign w_in_xfer  = (r_state == ST_LOAD) && in_valid;
  assign w_out_xfer = (r_state == ST_UNLOAD) && out_ready;

`ifdef ECC_OPERAND_CTRL_TIMEOUT_EN
  localparam int c_wd_w = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT_CYC - 1);

  logic [c_wd_w-1:0] r_wd;
  logic              r_error;

  assign w_wd_expired = (r_wd == c_wd_last);
  assign error        = r_error;

  // Cycle counter restarts every time WAIT is entered; error is sticky until rst
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd    <= '0;
      r_error <= 1'b0;
    end else begin
      r_wd <= (r_state == ST_WAIT) ? r_wd + 1'b1 : '0;
      if ((r_state == ST_WAIT) && !eng_done && w_wd_expired)
        r_error <= 1'b1;
    end
  end
`else
  assign w_wd_expired = 1'b0;
  assign error        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    eng_start = 1'b0;
    out_valid = 1'b0;
    busy      = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (r_idx == c_last_ld)) w_next = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        eng_start = 1'b1;
        w_next    = ST_WAIT;
      end
      ST_WAIT: begin
        if (eng_done) w_next = ST_UNLOAD;
`ifdef ECC_OPERAND_CTRL_TIMEOUT_EN
        else if (w_wd_expired) w_next = ST_ERR;
`endif
      end
      ST_UNLOAD: begin
        out_valid = 1'b1;
        if (out_ready && (r_idx == c_last_ul)) w_next = ST_IDLE;
      end
`ifdef ECC_OPERAND_CTRL_TIMEOUT_EN
      ST_ERR: begin
        if (!start) w_next = ST_IDLE;
      end
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  // One flat word index serves both phases and wraps at each phase end
  always_ff @(posedge clk) begin
    if (rst)
      r_idx <= '0;
    else if (w_in_xfer)
      r_idx <= (r_idx == c_last_ld) ? '0 : r_idx + 1'b1;
    else if (w_out_xfer)
      r_idx <= (r_idx == c_last_ul) ? '0 : r_idx + 1'b1;
  end

  // Each load slot keeps only the bits that belong to the operand
  for (genvar k = 0; k < c_n_ld; k++) begin : g_ld_word
    localparam int c_opnd = k / c_wpo;
    localparam int c_word = k % c_wpo;
    localparam int c_bits = (c_word == c_wpo - 1) ? c_top_w : WORD_W;

    logic [c_bits-1:0] r_word;

    always_ff @(posedge clk) begin
      if (rst)
        r_word <= '0;
      else if (w_in_xfer && (r_idx == c_idx_w'(k)))
        r_word <= data_in[c_bits-1:0];
    end

    assign eng_in[c_opnd*OPND_W + c_word*WORD_W +: c_bits] = r_word;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_res <= '0;
    else if ((r_state == ST_WAIT) && eng_done)
      r_res <= eng_out;
  end

  for (genvar j = 0; j < NUM_OUT; j++) begin : g_res_pad
    assign w_res_pad[j*c_pad_w +: c_pad_w] = c_pad_w'(r_res[j*OPND_W +: OPND_W]);
  end

  assign data_out = out_valid ? w_res_pad[r_idx*WORD_W +: WORD_W] : '0;

endmodule
`default_nettype wire

// File: tb/tb_ecc_operand_ctrl.sv
`default_nettype none
// Directed, table-driven bench for ecc_operand_ctrl at default widths.
module tb_ecc_operand_ctrl;

  localparam int WORD_W  = 64;
  localparam int OPND_W  = 164;
  localparam int NUM_IN  = 3;
  localparam int NUM_OUT = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      start;
  logic [WORD_W-1:0]         data_in;
  logic                      in_valid;
  logic                      in_ready;
  logic [NUM_IN*OPND_W-1:0]  eng_in;
  logic                      eng_start;
  logic                      eng_done;
  logic [NUM_OUT*OPND_W-1:0] eng_out;
  logic [WORD_W-1:0]         data_out;
  logic                      out_valid;
  logic                      out_ready;
  logic                      busy;
  logic                      error;

  int n_checks = 0;
  int n_fail   = 0;

  ecc_operand_ctrl #(
    .WORD_W(WORD_W), .OPND_W(OPND_W), .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .in_valid(in_valid),
    .in_ready(in_ready), .eng_in(eng_in), .eng_start(eng_start), .eng_done(eng_done),
    .eng_out(eng_out), .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9*64-1:0] in_w;
    logic [163:0]    pox;
    logic [163:0]    poy;
    logic [491:0]    exp_eng;
    logic [6*64-1:0] exp_out;
  } rec_t;

  rec_t vec [3];

  localparam logic [63:0] F = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic load(input int r, input bit bubble);
    for (int k = 0; k < 9; k++) begin
      if (bubble && k == 4) begin
        in_valid = 1'b0;
        data_in  = 64'hDEAD_DEAD_DEAD_DEAD;
        tick();
      end
      check("in_ready_load", in_ready, 1);
      data_in  = vec[r].in_w[k*64 +: 64];
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    data_in  = '0;
  endtask

  task automatic unload(input int r, input bit stall);
    for (int k = 0; k < 6; k++) begin
      if (stall && k == 2) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          check("hold_data_out", data_out, vec[r].exp_out[2*64 +: 64]);
          check("hold_out_valid", out_valid, 1);
        end
      end
      check("out_valid", out_valid, 1);
      check("data_out", data_out, vec[r].exp_out[k*64 +: 64]);
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
  endtask

  initial begin
    // Alternating ones/zeros, operand 0 = {36 ones, 64 zeros, 64 ones}
    vec[0].in_w    = {F, 64'h0, F, 64'h0, F, 64'h0, F, 64'h0, F};
    vec[0].pox     = 164'h1;
    vec[0].poy     = {164{1'b1}};
    vec[0].exp_eng = {{36'hFFFFFFFFF, 64'h0, F}, {36'h0, F, 64'h0}, {36'hFFFFFFFFF, 64'h0, F}};
    vec[0].exp_out = {64'h0000000FFFFFFFFF, F, F, 64'h0, 64'h0, 64'h1};
    // Distinct words; bits above the operand width in each top word are dropped
    vec[1].in_w    = {64'h0000001000000000, 64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555,
                      64'hFFFFFFFFFFFFFFF3, 64'h2, 64'h1,
                      64'hABCDE0123456789A, 64'hFEDCBA9876543210, 64'h0123456789ABCDEF};
    vec[1].pox     = {36'h800000001, 64'hDEADBEEF00000001, 64'hCAFEF00D12345678};
    vec[1].poy     = 164'h7;
    vec[1].exp_eng = {{36'h0, 64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555},
                      {36'hFFFFFFFF3, 64'h2, 64'h1},
                      {36'h23456789A, 64'hFEDCBA9876543210, 64'h0123456789ABCDEF}};
    vec[1].exp_out = {64'h0, 64'h0, 64'h7, 64'h0000000800000001,
                      64'hDEADBEEF00000001, 64'hCAFEF00D12345678};
    // All ones in, Pox all ones, Poy zero
    vec[2].in_w    = {9{F}};
    vec[2].pox     = {164{1'b1}};
    vec[2].poy     = 164'h0;
    vec[2].exp_eng = {492{1'b1}};
    vec[2].exp_out = {64'h0, 64'h0, 64'h0, 64'h0000000FFFFFFFFF, F, F};

    rst = 1'b1; start = 1'b0; data_in = '0; in_valid = 1'b0;
    eng_done = 1'b0; eng_out = '0; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_eng_in", eng_in, 0);
    rst = 1'b0;
    tick();
    check("idle_busy", busy, 0);
    eng_done = 1'b1; eng_out = {vec[0].poy, vec[0].pox};
    tick();
    eng_done = 1'b0;
    check("idle_done_ignored", out_valid, 0);
    check("idle_done_busy", busy, 0);

    for (int r = 0; r < 3; r++) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_load", busy, 1);
      load(r, r == 1);
      check("eng_start_pulse", eng_start, 1);
      check("launch_in_ready", in_ready, 0);
      tick();
      check("eng_start_single", eng_start, 0);
      check("eng_in", eng_in, vec[r].exp_eng);
      eng_out = {vec[r].poy, vec[r].pox};
      tick();
      check("wait_no_out_valid", out_valid, 0);
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      eng_out  = '0;
      check("done_to_out_valid", out_valid, 1);
      unload(r, r == 0);
      check("end_busy", busy, 0);
      check("end_out_valid", out_valid, 0);
      check("eng_in_stable", eng_in, vec[r].exp_eng);
    end

    // Start held high across back-to-back runs
    start = 1'b1;
    tick();
    load(0, 1'b0);
    tick();
    eng_out  = {vec[0].poy, vec[0].pox};
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    unload(0, 1'b0);
    check("b2b_idle_in_ready", in_ready, 0);
    check("b2b_idle_busy", busy, 0);
    tick();
    check("b2b_next_in_ready", in_ready, 1);
    start = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("b2b_rst_busy", busy, 0);

    // Reset while waiting on the engine, late eng_done ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    load(1, 1'b0);
    tick();
    tick();
    check("wait_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    eng_out  = {vec[1].poy, vec[1].pox};
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    check("rstwait_out_valid", out_valid, 0);
    check("rstwait_busy", busy, 0);
    check("rstwait_eng_in", eng_in, 0);
    tick();
    check("rstwait_out_valid2", out_valid, 0);

`ifdef ECC_OPERAND_CTRL_TIMEOUT_EN
    start = 1'b1;
    tick();
    load(2, 1'b0);
    tick();
    repeat (15) tick();
    check("wd_wait15_error", error, 0);
    check("wd_wait15_busy", busy, 1);
    tick();
    check("wd_wait16_error", error, 1);
    tick();
    check("wd_err_holds", busy, 1);
    start = 1'b0;
    tick();
    check("wd_idle_busy", busy, 0);
    check("wd_idle_error", error, 1);
    tick();
    check("wd_error_sticky", error, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("wd_rst_error", error, 0);
`else
    check("no_wd_error", error, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ecc_operand_ctrl.md
ECC_OPERAND_CTRL -- requirements
Module: ecc_operand_ctrl

Interface
REQ-001 The block SHALL have parameter WORD_W, default 64, host word width in bits.
REQ-002 The block SHALL have parameter OPND_W, default 164, engine operand width in bits.
REQ-003 The block SHALL have parameter NUM_IN, default 3, operands loaded per run (k, Pix, Piy).
REQ-004 The block SHALL have parameter NUM_OUT, default 2, results returned per run (Pox, Poy).
REQ-005 The block SHALL have parameter TIMEOUT_CYC, default 4096, engine watchdog limit in cycles.
REQ-006 The block SHALL have these ports: clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 start  in  1  level request to begin a run.
REQ-009 data_in  in  WORD_W  host input word; in_valid  in  1; in_ready  out  1.
REQ-010 eng_in  out  NUM_IN*OPND_W  assembled operands, operand i at bits [i*OPND_W +: OPND_W].
REQ-011 eng_start  out  1  one-cycle engine launch pulse; eng_done  in  1  engine completion.
REQ-012 eng_out  in  NUM_OUT*OPND_W  engine results, same packing as eng_in.
REQ-013 data_out  out  WORD_W; out_valid  out  1; out_ready  in  1  result stream.
REQ-014 busy  out  1  high in any state other than IDLE; error  out  1  sticky watchdog flag.

Function
REQ-015 WPO = ceil(OPND_W/WORD_W) SHALL be the words per operand (3 at defaults); load length is NUM_IN*WPO words and unload length is NUM_OUT*WPO words.
REQ-016 The FSM SHALL have states IDLE, LOAD, LAUNCH, WAIT, UNLOAD, and ERR (ERR only with the watchdog compiled in).
REQ-017 IDLE->LOAD when start=1; start SHALL be ignored in every other state.
REQ-018 In LOAD, in_ready=1; a word is transferred when in_valid&in_ready. Order: operand 0 first, least-significant word first. Bits of the top word above OPND_W are discarded.
REQ-019 LOAD->LAUNCH on the cycle the last word transfers. LAUNCH lasts exactly one cycle with eng_start=1, then goes to WAIT.
REQ-020 eng_in SHALL hold stable from LAUNCH until the next entry into LOAD.
REQ-021 In WAIT, eng_done=1 SHALL capture eng_out into an internal result register and go to UNLOAD. eng_done in any other state SHALL be ignored.
REQ-022 In UNLOAD, out_valid=1. data_out presents result words in the same order as the load, with bits above OPND_W zero-filled. A word advances when out_valid&out_ready.
REQ-023 With out_valid=1 and out_ready=0, data_out SHALL hold stable.
REQ-024 UNLOAD->IDLE after the last word transfers. If start=1 in that same cycle, the next run begins one cycle later from IDLE; there is no direct UNLOAD->LOAD.
REQ-025 Word/operand counters SHALL wrap to 0 at each phase boundary. Minimum latency is last input word -> eng_start = 1 cycle, and eng_done -> first out_valid = 1 cycle.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE from any state, including mid-LOAD, WAIT, or UNLOAD.
REQ-027 On reset, the counters, eng_in, and the result register SHALL clear to 0, and in_ready, eng_start, out_valid, data_out, busy, and error SHALL be 0.
REQ-028 An eng_done arriving after a reset SHALL be ignored.

Configuration
REQ-029 Macro ECC_OPERAND_CTRL_TIMEOUT_EN SHALL compile in the watchdog.
REQ-030 When defined: a counter starts at 0 on entry to WAIT. If it reaches TIMEOUT_CYC without eng_done, the FSM goes to ERR and error is set. ERR->IDLE when start=0, and error remains set until rst.
REQ-031 When undefined: WAIT is unbounded, ERR does not exist, and error is tied to 0.

Verification
REQ-032 Defaults: load 9 words alternating all-ones/all-zeros -> eng_start pulses 1 cycle after the 9th word. Operand 0 = {36'hFFFFFFFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF}.
REQ-033 eng_out = Pox 164'h1 and Poy all-ones, with out_ready=1 -> 6 words: 64'h1, 0, 0, then three words of all-ones with the 6th = 64'h0000000FFFFFFFFF.
REQ-034 out_ready held 0 for 5 cycles during UNLOAD -> data_out unchanged for those cycles and no word lost.
REQ-035 Assert rst in WAIT, then pulse eng_done -> no out_valid, busy=0, and eng_in reads 0.
REQ-036 With the macro defined and TIMEOUT_CYC=16, eng_done never asserted -> error=1 at WAIT cycle 16. After start falls: IDLE, with error still 1.
REQ-037 start held high across 2 runs -> exactly one IDLE cycle between the last out transfer and in_ready=1.
